// File: rtl/axis_addr_gen_pkg.sv
// Shared definitions for the AXI address-channel burst generator.
// The FSM state encoding and the default geometry constants live here.
// The top module derives its own constants from the same helper functions,
// so overridden parameters stay consistent.
// Optional feature macro: AXIS_ADDR_ALIGN_EN (see axis_addr_gen.sv).
package axis_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_BURST = 2'd2,
    ST_LAST  = 2'd3
  } state_e;

  localparam int DEF_CFG_DWIDTH     = 32;
  localparam int DEF_WIDTH_RATIO    = 16;
  localparam int DEF_CONVERT_SHIFT  = 4;
  localparam int DEF_AXI_LEN_WIDTH  = 8;
  localparam int DEF_AXI_ADDR_WIDTH = 32;

  // Bytes carried by one AXI data beat (stream word bytes * words per beat).
  function automatic int bytes_per_beat(input int dwidth, input int ratio);
    return (dwidth / 8) * ratio;
  endfunction

  // Beats in one maximum-length burst.
  function automatic int max_burst_beats(input int len_width);
    return 2 ** len_width;
  endfunction

  localparam int DEF_BYTES_PER_BEAT  = bytes_per_beat(DEF_CFG_DWIDTH, DEF_WIDTH_RATIO);
  localparam int DEF_MAX_BURST_BEATS = max_burst_beats(DEF_AXI_LEN_WIDTH);

endpackage

// File: rtl/axis_addr_gen.sv
// Splits one stream transfer request (byte address + length in stream words)
// into AXI4 address-channel bursts: as many max-length bursts as fit, then one
// trailing short burst for the remainder.
// Optional feature macro: AXIS_ADDR_ALIGN_EN -- when defined, the start
// address is aligned down to a beat boundary in SETUP; otherwise it is used
// verbatim and the caller owns alignment.
module axis_addr_gen
  import axis_addr_gen_pkg::*;
#(
  parameter int CFG_DWIDTH     = DEF_CFG_DWIDTH,
  parameter int WIDTH_RATIO    = DEF_WIDTH_RATIO,
  parameter int CONVERT_SHIFT  = DEF_CONVERT_SHIFT,
  parameter int AXI_LEN_WIDTH  = DEF_AXI_LEN_WIDTH,
  parameter int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      axi_aready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
  output logic                      axi_avalid
);

  localparam int BYTES_PER_BEAT  = bytes_per_beat(CFG_DWIDTH, WIDTH_RATIO);
  localparam int MAX_BURST_BEATS = max_burst_beats(AXI_LEN_WIDTH);
  // One extra bit so length + rounding term cannot overflow.
  localparam int BEATS_W = CFG_DWIDTH + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES =
    AXI_ADDR_WIDTH'(MAX_BURST_BEATS * BYTES_PER_BEAT);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [CFG_DWIDTH-1:0]     r_len;
  logic [BEATS_W-1:0]        r_burst_nb;
  logic [AXI_LEN_WIDTH-1:0]  r_last_nb;
  logic                      r_last_en;

  logic [BEATS_W-1:0]        w_beats;
  logic [BEATS_W-1:0]        w_burst_nb;
  logic                      w_burst_en;
  logic                      w_last_en;
  logic [AXI_ADDR_WIDTH-1:0] w_setup_addr;
  logic                      w_last_full;

  // Words -> beats rounding up, then split into full bursts and remainder.
  assign w_beats    = ({1'b0, r_len} + BEATS_W'(WIDTH_RATIO - 1)) >> CONVERT_SHIFT;
  assign w_burst_nb = w_beats >> AXI_LEN_WIDTH;
  assign w_burst_en = (w_burst_nb != '0);
  assign w_last_en  = (w_beats[AXI_LEN_WIDTH-1:0] != '0);

`ifdef AXIS_ADDR_ALIGN_EN
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES_PER_BEAT - 1);
  assign w_setup_addr = r_addr & ALIGN_MASK;
`else
  assign w_setup_addr = r_addr;
`endif

  // The full burst currently presented is the final one.
  assign w_last_full = (r_burst_nb == BEATS_W'(1));

  assign axi_aaddr = r_addr;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    axi_avalid  = 1'b0;
    axi_alen    = '0;
    unique case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_burst_en)     w_state_nxt = ST_BURST;
        else if (w_last_en) w_state_nxt = ST_LAST;
        else                w_state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        axi_avalid = 1'b1;
        axi_alen   = '1;
        if (axi_aready && w_last_full)
          w_state_nxt = r_last_en ? ST_LAST : ST_IDLE;
      end
      ST_LAST: begin
        axi_avalid = 1'b1;
        axi_alen   = r_last_nb - AXI_LEN_WIDTH'(1);
        if (axi_aready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, burst counters and address advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_burst_nb <= '0;
      r_last_nb  <= '0;
      r_last_en  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_addr <= AXI_ADDR_WIDTH'(cfg_address);
            r_len  <= cfg_length;
          end
        end
        ST_SETUP: begin
          r_addr     <= w_setup_addr;
          r_burst_nb <= w_burst_nb;
          r_last_nb  <= w_beats[AXI_LEN_WIDTH-1:0];
          r_last_en  <= w_last_en;
        end
        ST_BURST: begin
          // Address only moves on handshake, keeping AxADDR stable while stalled.
          if (axi_aready) begin
            r_burst_nb <= r_burst_nb - BEATS_W'(1);
            r_addr     <= r_addr + BURST_BYTES;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_addr_gen.sv
// Directed self-checking bench for axis_addr_gen (default parameters).
// Expected start addresses follow AXIS_ADDR_ALIGN_EN when the bench is
// compiled with the same macro as the design.
module tb_axis_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        axi_aready;
  logic [31:0] axi_aaddr;
  logic [7:0]  axi_alen;
  logic        axi_avalid;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef AXIS_ADDR_ALIGN_EN
  localparam logic [31:0] EXP_BASE = 32'd192;
`else
  localparam logic [31:0] EXP_BASE = 32'd255;
`endif
  localparam logic [31:0] BURST_BYTES = 32'd16384;

  axis_addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_address (cfg_address),
    .cfg_length  (cfg_length),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .axi_aready  (axi_aready),
    .axi_aaddr   (axi_aaddr),
    .axi_alen    (axi_alen),
    .axi_avalid  (axi_avalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one request at a negedge while idle; returns one negedge later
  // (DUT then in SETUP, no avalid yet).
  task automatic issue(input string tag, input logic [31:0] addr, input logic [31:0] len);
    cfg_address = addr;
    cfg_length  = len;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, " ready_low"}, cfg_ready, 1'b0);
    check({tag, " no_early_avalid"}, axi_avalid, 1'b0);
  endtask

  // Bounded wait for avalid, sampled on negedges.
  task automatic wait_avalid(input string tag);
    int n = 0;
    while (!axi_avalid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " avalid"}, axi_avalid, 1'b1);
  endtask

  task automatic check_burst(input string tag, input logic [31:0] addr, input logic [7:0] len);
    check({tag, " aaddr"}, axi_aaddr, addr);
    check({tag, " alen"}, axi_alen, len);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, cfg_ready, 1'b1);
    check({tag, " avalid"}, axi_avalid, 1'b0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    cfg_address = '0;
    cfg_length  = '0;
    cfg_valid   = 1'b0;
    axi_aready  = 1'b0;

    // 1: reset state
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check_burst("reset", 32'd0, 8'd0);
    rst = 1'b0;

    // 2: single short burst, aready held high
    axi_aready = 1'b1;
    issue("t2", 32'd255, 32'd576);
    wait_avalid("t2");
    check_burst("t2", EXP_BASE, 8'd35);
    @(negedge clk);
    check_idle("t2 done");

    // 3: two full bursts + remainder, stalls between handshakes
    axi_aready = 1'b0;
    issue("t3", 32'd255, 32'd9216);
    wait_avalid("t3");
    check_burst("t3 b0", EXP_BASE, 8'd255);
    @(negedge clk);
    check("t3 b0 hold avalid", axi_avalid, 1'b1);
    check_burst("t3 b0 hold", EXP_BASE, 8'd255);
    axi_aready = 1'b1;
    @(negedge clk);
    axi_aready = 1'b0;
    check_burst("t3 b1", EXP_BASE + BURST_BYTES, 8'd255);
    @(negedge clk);
    check("t3 b1 hold avalid", axi_avalid, 1'b1);
    check_burst("t3 b1 hold", EXP_BASE + BURST_BYTES, 8'd255);
    axi_aready = 1'b1;
    @(negedge clk);
    check_burst("t3 last", EXP_BASE + 2 * BURST_BYTES, 8'd63);
    check("t3 last avalid", axi_avalid, 1'b1);
    @(negedge clk);
    check_idle("t3 done");

    // 4: exactly two full bursts, no trailing burst
    issue("t4", 32'h0000_1000, 32'd8192);
    wait_avalid("t4");
    check_burst("t4 b0", 32'h0000_1000, 8'd255);
    @(negedge clk);
    check_burst("t4 b1", 32'h0000_5000, 8'd255);
    check("t4 b1 avalid", axi_avalid, 1'b1);
    @(negedge clk);
    check_idle("t4 done");

    // 4b: address wraps modulo 2^32
    issue("wrap", 32'hFFFF_C000, 32'd9216);
    wait_avalid("wrap");
    check_burst("wrap b0", 32'hFFFF_C000, 8'd255);
    @(negedge clk);
    check_burst("wrap b1", 32'h0000_0000, 8'd255);
    @(negedge clk);
    check_burst("wrap last", 32'h0000_4000, 8'd63);
    @(negedge clk);
    check_idle("wrap done");

    // 5: zero length -> no burst, ready within 3 cycles
    issue("len0", 32'h0000_0080, 32'd0);
    n = 0;
    while (!cfg_ready && n < 3) begin
      check("len0 no avalid", axi_avalid, 1'b0);
      @(negedge clk);
      n++;
    end
    check_idle("len0 done");
    // length 1 word -> one single-beat burst
    issue("len1", 32'h0000_0040, 32'd1);
    wait_avalid("len1");
    check_burst("len1", 32'h0000_0040, 8'd0);
    @(negedge clk);
    check_idle("len1 done");

    // 6: cfg_valid while busy ignored, then reset mid-burst
    axi_aready = 1'b0;
    issue("t6", 32'h0000_0100, 32'd9216);
    wait_avalid("t6");
    cfg_address = 32'h0000_8000;
    cfg_length  = 32'd16;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check_burst("t6 busy ignored", 32'h0000_0100, 8'd255);
    check("t6 busy ready", cfg_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t6 reset");
    check_burst("t6 reset", 32'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6 not queued", axi_avalid, 1'b0);
    end
    axi_aready = 1'b1;
    issue("t6 post", 32'h0000_0200, 32'd32);
    wait_avalid("t6 post");
    check_burst("t6 post", 32'h0000_0200, 8'd1);
    @(negedge clk);
    check_idle("t6 post done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
